pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 16-bit five-stage core.
- Generates stall, flush and bubble controls for the PC, the IF/ID register and the ID/EX register.
- Detects load-use hazards. Sequences the PC-hazard window for call/ret. Drains the pipe on HALT. Freezes the pipe while data memory is busy.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_pkg                                                |
// | Description : Shared types and constants for the pipeline hazard control.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        DRAIN     = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [3:0] REG_ZERO          = 4'd0;
    localparam int         DEF_CTRL_WAIT_CYC = 3;
    localparam int         DEF_DRAIN_CYC     = 3;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_detect                                                |
// | Description : Combinational load-use comparator between ID and EX.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [3:0] ex_reg_rd,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    output logic       load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = id_use_rs && (id_rs == ex_reg_rd);
    assign w_rt_hit = id_use_rt && (id_rt == ex_reg_rd);

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign load_use = ex_mem_read && (ex_reg_rd != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                             |
// | Description : Stall/flush/bubble sequencing for the five-stage core.       |
// |               Optional stall_cycles counter enabled by STALL_CNT_EN.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_WAIT_CYC = DEF_CTRL_WAIT_CYC,
    parameter int DRAIN_CYC     = DEF_DRAIN_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_call,
    input  logic        id_ret,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_reg_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic        pc_hazard,
    output logic        pc_release,
`ifdef STALL_CNT_EN
    output logic        halted,
    output logic [15:0] stall_cycles
`else
    output logic        halted
`endif
);

    localparam logic [2:0] c_wait_init  = 3'(CTRL_WAIT_CYC - 1);
    localparam logic [2:0] c_drain_init = 3'(DRAIN_CYC - 1);

    state_t     r_state;
    logic [2:0] r_cnt;
    state_t     w_state_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_load_use;

    logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_bubble;
    logic w_pipe_freeze, w_pc_hazard, w_pc_release, w_halted;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_reg_rd   (ex_reg_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .load_use    (w_load_use)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_freeze = 1'b0;
        w_pc_release  = 1'b0;
        w_pc_hazard   = (r_state == CTRL_WAIT);
        w_halted      = (r_state == HALTED);

        if (mem_busy) begin
            w_pipe_freeze = 1'b1;
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        // wrong-path ID instruction is squashed, so any call/ret/halt in it dies too
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (id_halt) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = c_drain_init;
                    end else if (id_call || id_ret) begin
                        w_state_nxt = CTRL_WAIT;
                        w_cnt_nxt   = c_wait_init;
                    end
                end
                CTRL_WAIT: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                    if (r_cnt == 3'd0) begin
                        w_pc_release = 1'b1;
                        w_state_nxt  = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                DRAIN: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = HALTED;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // outputs are forced low for the whole reset window, whatever the inputs do
    assign pc_stall    = rst_n & w_pc_stall;
    assign ifid_stall  = rst_n & w_ifid_stall;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign pipe_freeze = rst_n & w_pipe_freeze;
    assign pc_hazard   = rst_n & w_pc_hazard;
    assign pc_release  = rst_n & w_pc_release;
    assign halted      = rst_n & w_halted;

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (w_pc_stall && (r_state != HALTED) && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                          |
// | Description : Vector table, corner sequences and random run vs. a model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int CTRL_WAIT_CYC = 3;
    localparam int DRAIN_CYC     = 3;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       call;
        logic       ret;
        logic       halt;
        logic       mem_read;
        logic [3:0] rd;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp; // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_hazard, pc_release, halted}
    } vec_t;

    logic clk;
    logic rst_n;
    logic [3:0] id_rs, id_rt, ex_reg_rd;
    logic id_use_rs, id_use_rt, id_call, id_ret, id_halt, ex_mem_read, ex_branch_taken, mem_busy;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_hazard, pc_release, halted;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model: remaining window/drain cycles counted from the rules
    int win_left;
    int drain_left;
    bit halted_m;
    int stall_m;

    vec_t vecs[12];

    pipe_hazard_ctrl #(
        .CTRL_WAIT_CYC (CTRL_WAIT_CYC),
        .DRAIN_CYC     (DRAIN_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_call         (id_call),
        .id_ret          (id_ret),
        .id_halt         (id_halt),
        .ex_mem_read     (ex_mem_read),
        .ex_reg_rd       (ex_reg_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_freeze     (pipe_freeze),
        .pc_hazard       (pc_hazard),
        .pc_release      (pc_release),
`ifdef STALL_CNT_EN
        .halted          (halted),
        .stall_cycles    (stall_cycles)
`else
        .halted          (halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(input int rs, input int rt, input bit urs, input bit urt,
                               input bit call, input bit ret, input bit halt, input bit mr,
                               input int rd, input bit br, input bit busy);
        in_t v;
        v.rs = 4'(rs); v.rt = 4'(rt); v.use_rs = urs; v.use_rt = urt;
        v.call = call; v.ret = ret; v.halt = halt; v.mem_read = mr;
        v.rd = 4'(rd); v.br = br; v.busy = busy;
        return v;
    endfunction

    task automatic apply(input in_t v);
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        id_call = v.call; id_ret = v.ret; id_halt = v.halt; ex_mem_read = v.mem_read;
        ex_reg_rd = v.rd; ex_branch_taken = v.br; mem_busy = v.busy;
    endtask

    function automatic logic [7:0] dut_out();
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_hazard, pc_release, halted};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        bit lu, ps, is, fl, bub, frz, hz, rel, hl;
        lu = ex_mem_read && (ex_reg_rd != 4'd0) &&
             ((id_use_rs && id_rs == ex_reg_rd) || (id_use_rt && id_rt == ex_reg_rd));
        {ps, is, fl, bub, frz, rel} = '0;
        hz = (win_left > 0);
        hl = halted_m;
        if (mem_busy) begin
            ps = 1; is = 1; frz = 1;
        end else if (halted_m || drain_left > 0) begin
            ps = 1; fl = 1;
        end else if (win_left > 0) begin
            ps = 1; fl = 1; rel = (win_left == 1);
        end else if (ex_branch_taken) begin
            fl = 1; bub = 1;
        end else if (lu) begin
            ps = 1; is = 1; bub = 1;
        end
        return {ps, is, fl, bub, frz, hz, rel, hl};
    endfunction

    task automatic model_step(input logic [7:0] exp);
        bit lu;
        lu = exp[6]; // ifid_stall only rises on a load-use or a freeze
        if (exp[7] && !halted_m && stall_m < 65535) stall_m++;
        if (mem_busy || halted_m) return;
        if (win_left > 0) win_left--;
        else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) halted_m = 1;
        end else if (!ex_branch_taken && !lu) begin
            if (id_halt) drain_left = DRAIN_CYC;
            else if (id_call || id_ret) win_left = CTRL_WAIT_CYC;
        end
    endtask

    task automatic model_reset();
        win_left = 0; drain_left = 0; halted_m = 0; stall_m = 0;
    endtask

    task automatic tick_fixed(input string name, input logic [7:0] exp);
        logic [7:0] m;
        @(negedge clk);
        check(name, {8'h0, dut_out()}, {8'h0, exp});
        m = model_out();
        @(posedge clk);
        model_step(m);
        #1;
    endtask

    task automatic tick_model(input string name);
        logic [7:0] m;
        @(negedge clk);
        m = model_out();
        check(name, {8'h0, dut_out()}, {8'h0, m});
`ifdef STALL_CNT_EN
        check({name, "_cnt"}, stall_cycles, 16'(stall_m));
`endif
        @(posedge clk);
        model_step(m);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("reset_outputs", {8'h0, dut_out()}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic async_reset_check(input string name);
        mem_busy = 1'b1;
        rst_n = 1'b0;
        #1;
        check(name, {8'h0, dut_out()}, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        in_t idle;
        in_t v;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0);

        vecs[0]  = '{mk(5,0,1,0,0,0,0,1,5,0,0), 8'b1101_0000};
        vecs[1]  = '{mk(0,0,1,0,0,0,0,1,0,0,0), 8'b0000_0000};
        vecs[2]  = '{mk(2,9,0,1,0,0,0,1,9,0,0), 8'b1101_0000};
        vecs[3]  = '{mk(5,0,0,0,0,0,0,1,5,0,0), 8'b0000_0000};
        vecs[4]  = '{mk(5,0,1,0,0,0,0,0,5,0,0), 8'b0000_0000};
        vecs[5]  = '{mk(0,0,0,0,0,0,1,0,0,1,0), 8'b0011_0000};
        vecs[6]  = '{mk(5,0,1,0,0,0,0,1,5,1,0), 8'b0011_0000};
        vecs[7]  = '{mk(5,0,1,0,0,0,0,1,5,0,1), 8'b1100_1000};
        vecs[8]  = '{mk(0,0,0,0,0,0,0,0,0,1,1), 8'b1100_1000};
        vecs[9]  = '{mk(0,0,0,0,1,0,0,0,0,0,0), 8'b0000_0000};
        vecs[10] = '{mk(0,0,0,0,1,0,1,0,0,0,0), 8'b0000_0000};
        vecs[11] = '{mk(3,0,1,0,1,0,0,1,3,0,0), 8'b1101_0000};

        apply(idle);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_reset();
            apply(vecs[i].in);
            tick_fixed($sformatf("vec%0d", i), vecs[i].exp);
        end

        // call pulse: three-cycle window, release on the last
        do_reset();
        apply(mk(0,0,0,0,1,0,0,0,0,0,0)); tick_fixed("call_id", 8'b0000_0000);
        apply(idle);
        tick_fixed("call_w1", 8'b1010_0100);
        tick_fixed("call_w2", 8'b1010_0100);
        tick_fixed("call_w3", 8'b1010_0110);
        tick_fixed("call_run", 8'b0000_0000);

        // load-use stalled ret enters the window only after the stall
        do_reset();
        apply(mk(3,0,1,0,0,1,0,1,3,0,0)); tick_fixed("ret_lu", 8'b1101_0000);
        apply(mk(3,0,1,0,0,1,0,0,3,0,0)); tick_fixed("ret_go", 8'b0000_0000);
        apply(idle);
        tick_fixed("ret_w1", 8'b1010_0100);
        tick_fixed("ret_w2", 8'b1010_0100);
        tick_fixed("ret_w3", 8'b1010_0110);
        tick_fixed("ret_run", 8'b0000_0000);

        // freeze in the window with one cycle left before release
        do_reset();
        apply(mk(0,0,0,0,1,0,0,0,0,0,0)); tick_fixed("busy_call", 8'b0000_0000);
        apply(idle); tick_fixed("busy_w1", 8'b1010_0100);
        apply(mk(0,0,0,0,0,0,0,0,0,0,1));
        for (int i = 0; i < 4; i++) tick_fixed($sformatf("busy_hold%0d", i), 8'b1100_1100);
        apply(idle);
        tick_fixed("busy_w2", 8'b1010_0100);
        tick_fixed("busy_rel", 8'b1010_0110);
        tick_fixed("busy_run", 8'b0000_0000);

        // branch squashes a halt
        do_reset();
        apply(vecs[5].in); tick_fixed("br_halt", 8'b0011_0000);
        apply(idle);
        for (int i = 0; i < 5; i++) tick_fixed($sformatf("br_halt_after%0d", i), 8'b0000_0000);

        // halt drains for three cycles then sticks
        do_reset();
        apply(mk(0,0,0,0,0,0,1,0,0,0,0)); tick_fixed("halt_id", 8'b0000_0000);
        apply(idle);
        for (int i = 0; i < 3; i++) tick_fixed($sformatf("drain%0d", i), 8'b1010_0000);
        apply(mk(5,0,1,0,1,0,0,1,5,1,0));
        for (int i = 0; i < 3; i++) tick_fixed($sformatf("halted%0d", i), 8'b1010_0001);
        apply(mk(0,0,0,0,0,0,0,0,0,0,1)); tick_fixed("halted_busy", 8'b1100_1001);
        async_reset_check("async_rst_halted");
        tick_fixed("after_rst_halted", 8'b0000_0000);

        // reset aborts a call window
        do_reset();
        apply(mk(0,0,0,0,1,0,0,0,0,0,0)); tick_fixed("abort_call", 8'b0000_0000);
        apply(idle); tick_fixed("abort_w1", 8'b1010_0100);
        async_reset_check("async_rst_wait");
        tick_fixed("after_rst_wait", 8'b0000_0000);

`ifdef STALL_CNT_EN
        do_reset();
        apply(mk(5,0,1,0,0,0,0,1,5,0,0)); tick_fixed("cnt_lu1", 8'b1101_0000);
        apply(idle);                       tick_fixed("cnt_idle1", 8'b0000_0000);
        apply(mk(0,6,0,1,0,0,0,1,6,0,0)); tick_fixed("cnt_lu2", 8'b1101_0000);
        apply(mk(0,0,0,0,1,0,0,0,0,0,0)); tick_fixed("cnt_call", 8'b0000_0000);
        apply(idle);
        for (int i = 0; i < 4; i++) tick_model("cnt_wait");
        check("stall_cycles", stall_cycles, 16'd5);
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) do_reset();
            v.rs       = 4'($urandom_range(0, 3));
            v.rt       = 4'($urandom_range(0, 3));
            v.use_rs   = 1'($urandom_range(0, 1));
            v.use_rt   = 1'($urandom_range(0, 1));
            v.call     = ($urandom_range(0, 9) == 0);
            v.ret      = ($urandom_range(0, 11) == 0);
            v.halt     = ($urandom_range(0, 59) == 0);
            v.mem_read = ($urandom_range(0, 2) == 0);
            v.rd       = 4'($urandom_range(0, 3));
            v.br       = ($urandom_range(0, 7) == 0);
            v.busy     = ($urandom_range(0, 5) == 0);
            apply(v);
            tick_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
